alu_issue_ctrl: RTL and testbench

Execute-stage controller that sits on the initiator side of the ALU_RV32I interface. It accepts RV32I R/I/U-type instructions plus register operands over a valid/ready handshake, decodes them to a 4-bit ALU op, and drives registered op/a/b into the ALU. It then captures the ALU result and presents it with its destination register to writeback over a second valid/ready handshake. One instruction is in flight at a time.

---
 rtl/alu_issue_ctrl_if.sv | 36 +++
 rtl/alu_issue_ctrl.sv | 197 +++++++++++++++++++
 tb/tb_alu_issue_ctrl.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/alu_issue_ctrl_if.sv
// rtl/alu_issue_ctrl_if.sv - Issue, ALU and writeback signal bundle for alu_issue_ctrl
//
// Purpose: groups the instruction-in handshake, the ALU operand/result pins
// and the writeback handshake of the execute-stage controller.
// Modports:
//   slave  - controller view (alu_issue_ctrl): consumes instr/operands and
//            the ALU result; drives in_ready, alu_op/a/b, out_* and illegal.
//   master - environment view (decode stage, ALU, writeback).
interface alu_issue_ctrl_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      instr;
    logic [WIDTH-1:0] rs1_val;
    logic [WIDTH-1:0] rs2_val;
    logic [3:0]       alu_op;
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [WIDTH-1:0] alu_o;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_result;
    logic [4:0]       out_rd;
    logic             illegal;

    modport slave (
        input  in_valid, instr, rs1_val, rs2_val, alu_o, out_ready,
        output in_ready, alu_op, alu_a, alu_b, out_valid, out_result, out_rd, illegal
    );

    modport master (
        output in_valid, instr, rs1_val, rs2_val, alu_o, out_ready,
        input  in_ready, alu_op, alu_a, alu_b, out_valid, out_result, out_rd, illegal
    );
endinterface

// File: rtl/alu_issue_ctrl.sv
// rtl/alu_issue_ctrl.sv - RV32I execute-stage issue controller driving an external ALU
//
// Purpose: accepts one RV32I R/I/U-type instruction at a time, decodes it to
// a 4-bit ALU op, drives registered op/a/b into the ALU, captures the ALU
// result and hands it to writeback with its destination register.
// Ports:
//   clk   - rising-edge clock
//   rst_n - asynchronous active-low reset
//   bus   - alu_issue_ctrl_if.slave: instruction handshake, ALU pins,
//           writeback handshake and the one-cycle illegal pulse
module alu_issue_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    alu_issue_ctrl_if.slave   bus
);
    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_MUL  = 4'b0010;
    localparam logic [3:0] OP_AND  = 4'b0011;
    localparam logic [3:0] OP_OR   = 4'b0100;
    localparam logic [3:0] OP_XOR  = 4'b0101;
    localparam logic [3:0] OP_SLL  = 4'b0110;
    localparam logic [3:0] OP_SRL  = 4'b0111;
    localparam logic [3:0] OP_SRA  = 4'b1000;
    localparam logic [3:0] OP_SLT  = 4'b1001;
    localparam logic [3:0] OP_SLTU = 4'b1010;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_WB} state_t;

    state_t           r_state;
    logic [3:0]       r_alu_op;
    logic [WIDTH-1:0] r_alu_a;
    logic [WIDTH-1:0] r_alu_b;
    logic [WIDTH-1:0] r_out_result;
    logic [4:0]       r_out_rd;
    logic             r_out_valid;
    logic             r_illegal;

    logic             w_legal;
    logic [3:0]       w_op;
    logic [WIDTH-1:0] w_a;
    logic [WIDTH-1:0] w_b;
    logic [6:0]       w_opcode;
    logic [2:0]       w_funct3;
    logic [6:0]       w_funct7;
    logic             w_accept;

    // Base funct3 mapping shared by R-type (funct7 0) and I-type.
    function automatic logic [3:0] f3_op(input logic [2:0] f3);
        case (f3)
            3'b000:  return OP_ADD;
            3'b001:  return OP_SLL;
            3'b010:  return OP_SLT;
            3'b011:  return OP_SLTU;
            3'b100:  return OP_XOR;
            3'b101:  return OP_SRL;
            3'b110:  return OP_OR;
            default: return OP_AND;
        endcase
    endfunction

    assign w_opcode = bus.instr[6:0];
    assign w_funct3 = bus.instr[14:12];
    assign w_funct7 = bus.instr[31:25];

    always_comb begin
        w_legal = 1'b0;
        w_op    = OP_ADD;
        w_a     = bus.rs1_val;
        w_b     = bus.rs2_val;
        case (w_opcode)
            7'b0110011: begin
                case (w_funct7)
                    7'b0000000: begin
                        w_legal = 1'b1;
                        w_op    = f3_op(w_funct3);
                    end
                    7'b0100000: begin
                        if (w_funct3 == 3'b000) begin
                            w_legal = 1'b1;
                            w_op    = OP_SUB;
                        end else if (w_funct3 == 3'b101) begin
                            w_legal = 1'b1;
                            w_op    = OP_SRA;
                        end
                    end
                    7'b0000001: begin
                        if (w_funct3 == 3'b000) begin
                            w_legal = 1'b1;
                            w_op    = OP_MUL;
                        end
                    end
                    default: ;
                endcase
            end
            7'b0010011: begin
                w_b = WIDTH'({{20{bus.instr[31]}}, bus.instr[31:20]});
                case (w_funct3)
                    3'b001: begin
                        // Shift immediates use only the 5-bit shamt field.
                        w_b     = WIDTH'(bus.instr[24:20]);
                        w_op    = OP_SLL;
                        w_legal = (w_funct7 == 7'b0000000);
                    end
                    3'b101: begin
                        w_b = WIDTH'(bus.instr[24:20]);
                        if (w_funct7 == 7'b0000000) begin
                            w_legal = 1'b1;
                            w_op    = OP_SRL;
                        end else if (w_funct7 == 7'b0100000) begin
                            w_legal = 1'b1;
                            w_op    = OP_SRA;
                        end
                    end
                    default: begin
                        w_legal = 1'b1;
                        w_op    = f3_op(w_funct3);
                    end
                endcase
            end
            7'b0110111: begin
                // LUI is executed as 0 + upper immediate.
                w_legal = 1'b1;
                w_op    = OP_ADD;
                w_a     = '0;
                w_b     = WIDTH'({bus.instr[31:12], 12'b0});
            end
            default: ;
        endcase
    end

    // In WAIT_WB a new instruction may enter on the same edge the result
    // leaves, so readiness follows the writeback side.
    assign bus.in_ready = (r_state == IDLE) || ((r_state == WAIT_WB) && bus.out_ready);
    assign w_accept     = bus.in_valid && bus.in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_alu_op     <= '0;
            r_alu_a      <= '0;
            r_alu_b      <= '0;
            r_out_result <= '0;
            r_out_rd     <= '0;
            r_out_valid  <= 1'b0;
            r_illegal    <= 1'b0;
        end else begin
            r_illegal <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        if (w_legal) begin
                            r_alu_op <= w_op;
                            r_alu_a  <= w_a;
                            r_alu_b  <= w_b;
                            r_out_rd <= bus.instr[11:7];
                            r_state  <= ISSUE;
                        end else begin
                            r_illegal <= 1'b1;
                        end
                    end
                end
                ISSUE: begin
                    r_out_result <= bus.alu_o;
                    r_out_valid  <= 1'b1;
                    r_state      <= WAIT_WB;
                end
                WAIT_WB: begin
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        if (w_accept && w_legal) begin
                            r_alu_op <= w_op;
                            r_alu_a  <= w_a;
                            r_alu_b  <= w_b;
                            r_out_rd <= bus.instr[11:7];
                            r_state  <= ISSUE;
                        end else begin
                            r_illegal <= w_accept;
                            r_state   <= IDLE;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.alu_op     = r_alu_op;
    assign bus.alu_a      = r_alu_a;
    assign bus.alu_b      = r_alu_b;
    assign bus.out_result = r_out_result;
    assign bus.out_rd     = r_out_rd;
    assign bus.out_valid  = r_out_valid;
    assign bus.illegal    = r_illegal;
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb/tb_alu_issue_ctrl.sv - Scoreboard testbench for alu_issue_ctrl
module tb_alu_issue_ctrl;
    logic clk;
    logic rst_n;

    alu_issue_ctrl_if #(.WIDTH(32)) bus ();

    alu_issue_ctrl #(.WIDTH(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External ALU model
    always_comb begin
        case (bus.alu_op)
            4'd0:    bus.alu_o = bus.alu_a + bus.alu_b;
            4'd1:    bus.alu_o = bus.alu_a - bus.alu_b;
            4'd2:    bus.alu_o = bus.alu_a * bus.alu_b;
            4'd3:    bus.alu_o = bus.alu_a & bus.alu_b;
            4'd4:    bus.alu_o = bus.alu_a | bus.alu_b;
            4'd5:    bus.alu_o = bus.alu_a ^ bus.alu_b;
            4'd6:    bus.alu_o = bus.alu_a << bus.alu_b[4:0];
            4'd7:    bus.alu_o = bus.alu_a >> bus.alu_b[4:0];
            4'd8:    bus.alu_o = $unsigned($signed(bus.alu_a) >>> bus.alu_b[4:0]);
            4'd9:    bus.alu_o = {31'b0, ($signed(bus.alu_a) < $signed(bus.alu_b))};
            4'd10:   bus.alu_o = {31'b0, (bus.alu_a < bus.alu_b)};
            default: bus.alu_o = 32'b0;
        endcase
    end

    typedef struct packed {
        logic [31:0] res;
        logic [4:0]  rd;
    } exp_t;

    exp_t sb_q[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
        end
    endtask

    // Monitor: every writeback handshake pops one expected result.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && bus.out_valid && bus.out_ready) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_result", 32'd1, 32'd0);
                end else begin
                    e = sb_q.pop_front();
                    check("out_result", bus.out_result, e.res);
                    check("out_rd", {27'b0, bus.out_rd}, {27'b0, e.rd});
                end
            end
        end
    end

    // Present an instruction at posedge+1 and wait for it to be accepted.
    task automatic issue(input logic [31:0] ins, input logic [31:0] r1, input logic [31:0] r2,
                         input bit legal, input bit push, input logic [3:0] eop,
                         input logic [31:0] ea, input logic [31:0] eb, input logic [31:0] eres,
                         output int waited);
        bit   ok;
        exp_t e;
        bus.instr    = ins;
        bus.rs1_val  = r1;
        bus.rs2_val  = r2;
        bus.in_valid = 1'b1;
        waited = 0;
        ok     = 1'b0;
        while (!ok && waited < 20) begin
            @(negedge clk);
            ok = bus.in_ready;
            @(posedge clk);
            #1;
            waited++;
        end
        bus.in_valid = 1'b0;
        if (!ok) begin
            check("accept_timeout", 32'd0, 32'd1);
            return;
        end
        if (legal && push) begin
            e.res = eres;
            e.rd  = ins[11:7];
            sb_q.push_back(e);
        end
        check("alu_op", {28'b0, bus.alu_op}, {28'b0, eop});
        check("alu_a", bus.alu_a, ea);
        check("alu_b", bus.alu_b, eb);
        check("out_valid_after_accept", {31'b0, bus.out_valid}, 32'd0);
        check("illegal_after_accept", {31'b0, bus.illegal}, {31'b0, !legal});
        if (!legal) begin
            check("in_ready_after_illegal", {31'b0, bus.in_ready}, 32'd1);
            @(posedge clk);
            #1;
            check("illegal_pulse_len", {31'b0, bus.illegal}, 32'd0);
            check("out_valid_after_illegal", {31'b0, bus.out_valid}, 32'd0);
        end else if (push) begin
            @(posedge clk);
            #1;
            check("latency_out_valid", {31'b0, bus.out_valid}, 32'd1);
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((sb_q.size() != 0 || bus.out_valid) && n < 10) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 10) check("drain_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        int w;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.instr     = 32'b0;
        bus.rs1_val   = 32'b0;
        bus.rs2_val   = 32'b0;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", {31'b0, bus.in_ready}, 32'd1);
        check("rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
        check("rst_alu_op", {28'b0, bus.alu_op}, 32'd0);
        check("rst_alu_a", bus.alu_a, 32'd0);
        check("rst_alu_b", bus.alu_b, 32'd0);
        check("rst_out_result", bus.out_result, 32'd0);
        check("rst_out_rd", {27'b0, bus.out_rd}, 32'd0);
        check("rst_illegal", {31'b0, bus.illegal}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // addi x5,x1,-3
        issue(32'hFFD08293, 32'd10, 32'd0, 1, 1, 4'b0000, 32'd10, 32'hFFFFFFFD, 32'd7, w);
        // sub x3,x1,x2 back-to-back
        issue(32'h402081B3, 32'd4, 32'd3, 1, 1, 4'b0001, 32'd4, 32'd3, 32'd1, w);
        check("back_to_back_wait", w, 32'd1);
        // mul x6,x3,x2
        issue(32'h02218333, 32'd3, 32'd2, 1, 1, 4'b0010, 32'd3, 32'd2, 32'd6, w);
        // sltu x7,x1,x2
        issue(32'h0020B3B3, 32'd1, 32'hFFFFFFFF, 1, 1, 4'b1010, 32'd1, 32'hFFFFFFFF, 32'd1, w);
        // srai x4,x4,4
        issue(32'h40425213, 32'h80000000, 32'd0, 1, 1, 4'b1000, 32'h80000000, 32'd4, 32'hF8000000, w);
        // lui x1,0x12345
        issue(32'h123450B7, 32'hDEADBEEF, 32'd0, 1, 1, 4'b0000, 32'd0, 32'h12345000, 32'h12345000, w);
        drain();

        // Illegal opcode, then slli with a nonzero funct7; ALU regs must keep lui values
        issue(32'h0000007F, 32'd1, 32'd2, 0, 0, 4'b0000, 32'd0, 32'h12345000, 32'd0, w);
        issue(32'h02009093, 32'd1, 32'd2, 0, 0, 4'b0000, 32'd0, 32'h12345000, 32'd0, w);

        // Backpressure: result held for 5 cycles, then release with a waiting instruction
        bus.out_ready = 1'b0;
        issue(32'hFFD08293, 32'd20, 32'd0, 1, 1, 4'b0000, 32'd20, 32'hFFFFFFFD, 32'd17, w);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("bp_out_valid", {31'b0, bus.out_valid}, 32'd1);
            check("bp_out_result", bus.out_result, 32'd17);
            check("bp_out_rd", {27'b0, bus.out_rd}, 32'd5);
            check("bp_in_ready", {31'b0, bus.in_ready}, 32'd0);
        end
        bus.out_ready = 1'b1;
        issue(32'h402081B3, 32'd9, 32'd4, 1, 1, 4'b0001, 32'd9, 32'd4, 32'd5, w);
        check("bp_no_bubble", w, 32'd1);
        drain();

        // Async reset while in ISSUE aborts the instruction
        issue(32'h402081B3, 32'd7, 32'd2, 1, 0, 4'b0001, 32'd7, 32'd2, 32'd5, w);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_out_valid", {31'b0, bus.out_valid}, 32'd0);
        check("arst_alu_op", {28'b0, bus.alu_op}, 32'd0);
        check("arst_alu_a", bus.alu_a, 32'd0);
        check("arst_alu_b", bus.alu_b, 32'd0);
        check("arst_out_result", bus.out_result, 32'd0);
        check("arst_out_rd", {27'b0, bus.out_rd}, 32'd0);
        check("arst_in_ready", {31'b0, bus.in_ready}, 32'd1);
        #3;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            check("arst_no_result", {31'b0, bus.out_valid}, 32'd0);
        end
        check("sb_empty", sb_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
